// File: rtl/adxl362_access_scheduler.sv
// Access scheduler in front of the adxl362_controller SPI engine: one-time init write,
// periodic X/Y/Z poll, and a manual read/write requester, serialised onto one start/done port.
module adxl362_access_scheduler #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int POLL_RATE     = 2,
    parameter int TIMEOUT_CLKS  = 4096,
    parameter int INIT_ENABLE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       man_req,
    input  logic       man_write,
    input  logic [7:0] man_addr,
    input  logic [7:0] man_wdata,
    output logic       man_ack,
    output logic       man_done,
    output logic [7:0] man_rdata,
    output logic       ctrl_start,
    output logic       ctrl_write,
    output logic [7:0] ctrl_addr,
    output logic [7:0] ctrl_wdata,
    input  logic       ctrl_busy,
    input  logic       ctrl_done,
    input  logic [7:0] ctrl_rdata,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic [7:0] z_data,
    output logic       xyz_valid,
    output logic       sched_busy,
    output logic       timeout_err,
    output logic       poll_overrun
);

    localparam int POLL_CLKS = CLK_FREQUENCY / POLL_RATE;
    localparam int PW        = (POLL_CLKS > 1) ? $clog2(POLL_CLKS) : 1;
    localparam int TW        = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CLKS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ST_INIT_ISSUE = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_ISSUE      = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_MAN  = 2'd1;
    localparam logic [1:0] OP_POLL = 2'd2;

    localparam logic [1:0] ST_RESET = (INIT_ENABLE != 0) ? ST_INIT_ISSUE : ST_IDLE;

    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;
    localparam logic [7:0] REG_XDATA     = 8'h08;
    localparam logic [7:0] REG_YDATA     = 8'h09;
    localparam logic [7:0] REG_ZDATA     = 8'h0A;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [1:0]    axis_q, axis_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_pending_q, poll_pending_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ctrl_start_q, ctrl_start_d;
    logic          ctrl_write_q, ctrl_write_d;
    logic [7:0]    ctrl_addr_q, ctrl_addr_d;
    logic [7:0]    ctrl_wdata_q, ctrl_wdata_d;
    logic          man_ack_q, man_ack_d;
    logic          man_done_q, man_done_d;
    logic [7:0]    man_rdata_q, man_rdata_d;
    logic [7:0]    x_sh_q, x_sh_d;
    logic [7:0]    y_sh_q, y_sh_d;
    logic [7:0]    x_data_q, x_data_d;
    logic [7:0]    y_data_q, y_data_d;
    logic [7:0]    z_data_q, z_data_d;
    logic          xyz_valid_q, xyz_valid_d;
    logic          sched_busy_q, sched_busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic          poll_overrun_q, poll_overrun_d;
    logic          poll_tick;
    logic          poll_take;

    // Manual handshake: man_req is a level held by the requester until man_ack pulses; the
    // man_* fields are captured on the grant cycle, so they may change once man_ack is seen.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        axis_d         = axis_q;
        tmo_cnt_d      = tmo_cnt_q;
        ctrl_start_d   = 1'b0;
        ctrl_write_d   = ctrl_write_q;
        ctrl_addr_d    = ctrl_addr_q;
        ctrl_wdata_d   = ctrl_wdata_q;
        man_ack_d      = 1'b0;
        man_done_d     = 1'b0;
        man_rdata_d    = man_rdata_q;
        x_sh_d         = x_sh_q;
        y_sh_d         = y_sh_q;
        x_data_d       = x_data_q;
        y_data_d       = y_data_q;
        z_data_d       = z_data_q;
        xyz_valid_d    = 1'b0;
        timeout_err_d  = 1'b0;
        poll_take      = 1'b0;

        poll_tick  = (poll_cnt_q == POLL_LAST);
        poll_cnt_d = poll_tick ? '0 : poll_cnt_q + PW'(1);

        case (state_q)
            ST_INIT_ISSUE: begin
                op_d         = OP_INIT;
                ctrl_write_d = 1'b1;
                ctrl_addr_d  = REG_POWER_CTL;
                ctrl_wdata_d = PWR_MEASURE;
                if (!ctrl_busy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_IDLE: begin
                if (!ctrl_busy) begin
                    if (man_req) begin
                        op_d         = OP_MAN;
                        ctrl_write_d = man_write;
                        ctrl_addr_d  = man_addr;
                        ctrl_wdata_d = man_wdata;
                        man_ack_d    = 1'b1;
                        state_d      = ST_ISSUE;
                    end else if (poll_pending_q) begin
                        poll_take    = 1'b1;
                        op_d         = OP_POLL;
                        axis_d       = 2'd0;
                        ctrl_write_d = 1'b0;
                        ctrl_addr_d  = REG_XDATA;
                        ctrl_wdata_d = 8'h00;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                ctrl_start_d = 1'b1;
                tmo_cnt_d    = '0;
                state_d      = ST_WAIT_DONE;
            end
            default: begin
                if (ctrl_done) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_MAN: begin
                            man_done_d = 1'b1;
                            if (!ctrl_write_q) begin
                                man_rdata_d = ctrl_rdata;
                            end
                        end
                        OP_POLL: begin
                            // Axes chain straight back to ISSUE so nothing can slip in mid-sequence.
                            case (axis_q)
                                2'd0: begin
                                    x_sh_d      = ctrl_rdata;
                                    axis_d      = 2'd1;
                                    ctrl_addr_d = REG_YDATA;
                                    state_d     = ST_ISSUE;
                                end
                                2'd1: begin
                                    y_sh_d      = ctrl_rdata;
                                    axis_d      = 2'd2;
                                    ctrl_addr_d = REG_ZDATA;
                                    state_d     = ST_ISSUE;
                                end
                                default: begin
                                    x_data_d    = x_sh_q;
                                    y_data_d    = y_sh_q;
                                    z_data_d    = ctrl_rdata;
                                    xyz_valid_d = 1'b1;
                                end
                            endcase
                        end
                        default: begin
                        end
                    endcase
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
        endcase

        // A tick landing on the cycle the old request is consumed re-arms it instead of overrunning.
        poll_pending_d = (poll_pending_q & ~poll_take) | poll_tick;
        poll_overrun_d = poll_tick & poll_pending_q & ~poll_take;
        sched_busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RESET;
            op_q           <= OP_INIT;
            axis_q         <= 2'd0;
            poll_cnt_q     <= '0;
            poll_pending_q <= 1'b0;
            tmo_cnt_q      <= '0;
            ctrl_start_q   <= 1'b0;
            ctrl_write_q   <= 1'b0;
            ctrl_addr_q    <= 8'h00;
            ctrl_wdata_q   <= 8'h00;
            man_ack_q      <= 1'b0;
            man_done_q     <= 1'b0;
            man_rdata_q    <= 8'h00;
            x_sh_q         <= 8'h00;
            y_sh_q         <= 8'h00;
            x_data_q       <= 8'h00;
            y_data_q       <= 8'h00;
            z_data_q       <= 8'h00;
            xyz_valid_q    <= 1'b0;
            sched_busy_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            poll_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            axis_q         <= axis_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_pending_q <= poll_pending_d;
            tmo_cnt_q      <= tmo_cnt_d;
            ctrl_start_q   <= ctrl_start_d;
            ctrl_write_q   <= ctrl_write_d;
            ctrl_addr_q    <= ctrl_addr_d;
            ctrl_wdata_q   <= ctrl_wdata_d;
            man_ack_q      <= man_ack_d;
            man_done_q     <= man_done_d;
            man_rdata_q    <= man_rdata_d;
            x_sh_q         <= x_sh_d;
            y_sh_q         <= y_sh_d;
            x_data_q       <= x_data_d;
            y_data_q       <= y_data_d;
            z_data_q       <= z_data_d;
            xyz_valid_q    <= xyz_valid_d;
            sched_busy_q   <= sched_busy_d;
            timeout_err_q  <= timeout_err_d;
            poll_overrun_q <= poll_overrun_d;
        end
    end

    assign man_ack      = man_ack_q;
    assign man_done     = man_done_q;
    assign man_rdata    = man_rdata_q;
    assign ctrl_start   = ctrl_start_q;
    assign ctrl_write   = ctrl_write_q;
    assign ctrl_addr    = ctrl_addr_q;
    assign ctrl_wdata   = ctrl_wdata_q;
    assign x_data       = x_data_q;
    assign y_data       = y_data_q;
    assign z_data       = z_data_q;
    assign xyz_valid    = xyz_valid_q;
    assign sched_busy   = sched_busy_q;
    assign timeout_err  = timeout_err_q;
    assign poll_overrun = poll_overrun_q;

endmodule
